// File: rtl/gauss_eliminate_if.sv
// Handshake and matrix buses between a system producer and the forward-elimination stage.
// Master drives the system in; slave returns the triangular result and status.
interface gauss_eliminate_if #(parameter int N = 3);
    logic in_valid;
    real  A [N][N];
    real  y [N];
    logic busy;
    logic out_valid;
    real  M [N][N];
    real  b [N];
    logic singular;

    modport master (output in_valid, A, y, input busy, out_valid, M, b, singular);
    modport slave  (input in_valid, A, y, output busy, out_valid, M, b, singular);
endinterface

// File: rtl/gauss_eliminate.sv
// Forward elimination with partial pivoting, one row operation per clock; result after
// (N-1)+N(N-1)/2 edges (1 for N=1); in_valid is only taken when idle, never queued.
module gauss_eliminate #(
    parameter int  N   = 3,
    parameter real EPS = 0.0
) (
    input logic          clk,
    input logic          reset,
    gauss_eliminate_if.slave io
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, PIVOT, ELIM} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] k_q, k_d, i_q, i_d, p;
    real           wm_q [N][N];
    real           wm_d [N][N];
    real           wb_q [N];
    real           wb_d [N];
    logic          sing_q, sing_d, busy_q, busy_d, ov_q, ov_d;
    logic          done;
    real           pmax, f;

    function automatic real fabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        i_d     = i_q;
        wm_d    = wm_q;
        wb_d    = wb_q;
        sing_d  = sing_q;
        busy_d  = busy_q;
        ov_d    = 1'b0;
        done    = 1'b0;
        p       = k_q;
        pmax    = 0.0;
        f       = 0.0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (io.in_valid) begin
                    wm_d    = io.A;
                    wb_d    = io.y;
                    k_d     = '0;
                    sing_d  = 1'b0;
                    state_d = PIVOT;
                end
            end
            PIVOT: begin
                pmax = fabs(wm_q[k_q][k_q]);
                for (int r = 0; r < N; r++) begin
                    if (r > int'(k_q) && fabs(wm_q[r][k_q]) > pmax) begin
                        p    = IW'(r);
                        pmax = fabs(wm_q[r][k_q]);
                    end
                end
                // Swap reads only registered rows, so p == k is a harmless self-copy.
                for (int c = 0; c < N; c++) begin
                    wm_d[k_q][c] = wm_q[p][c];
                    wm_d[p][c]   = wm_q[k_q][c];
                end
                wb_d[k_q] = wb_q[p];
                wb_d[p]   = wb_q[k_q];
                if (pmax <= EPS)
                    sing_d = 1'b1;
                if (N == 1 || (pmax <= EPS && int'(k_q) == N - 2)) begin
                    done = 1'b1;
                end else if (pmax <= EPS) begin
                    k_d = k_q + 1'b1;
                end else begin
                    i_d     = k_q + 1'b1;
                    state_d = ELIM;
                end
            end
            ELIM: begin
                f = wm_q[i_q][k_q] / wm_q[k_q][k_q];
                for (int c = 0; c < N; c++) begin
                    if (c > int'(k_q))
                        wm_d[i_q][c] = wm_q[i_q][c] - f * wm_q[k_q][c];
                end
                wm_d[i_q][k_q] = 0.0;
                wb_d[i_q]      = wb_q[i_q] - f * wb_q[k_q];
                if (int'(i_q) == N - 1) begin
                    if (int'(k_q) == N - 2) begin
                        done = 1'b1;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = PIVOT;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE)
            busy_d = ~done;
        if (done) begin
            state_d = IDLE;
            ov_d    = 1'b1;
            // Last diagonal is never pivoted, so it is judged after this edge's update.
            if (fabs(wm_d[N-1][N-1]) <= EPS)
                sing_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            i_q     <= '0;
            sing_q  <= 1'b0;
            busy_q  <= 1'b0;
            ov_q    <= 1'b0;
            for (int r = 0; r < N; r++) begin
                wb_q[r] <= 0.0;
                for (int c = 0; c < N; c++)
                    wm_q[r][c] <= 0.0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            sing_q  <= sing_d;
            busy_q  <= busy_d;
            ov_q    <= ov_d;
            wm_q    <= wm_d;
            wb_q    <= wb_d;
        end
    end

    assign io.M         = wm_q;
    assign io.b         = wb_q;
    assign io.busy      = busy_q;
    assign io.out_valid = ov_q;
    assign io.singular  = sing_q;
endmodule

// File: tb/tb_gauss_eliminate.sv
// Directed bench for gauss_eliminate (N=3 and N=1) against a plain Gaussian-elimination model.
module tb_gauss_eliminate;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gauss_eliminate_if #(.N(3)) io3();
    gauss_eliminate_if #(.N(1)) io1();

    gauss_eliminate #(.N(3), .EPS(0.0)) dut3 (.clk(clk), .reset(reset), .io(io3.slave));
    gauss_eliminate #(.N(1), .EPS(0.0)) dut1 (.clk(clk), .reset(reset), .io(io1.slave));

    int  nchk = 0;
    int  nerr = 0;
    int  cyc  = 0;
    real ga [3][3];
    real gy [3];
    real eM [3][3];
    real eb [3];
    bit  es;
    int  ecap, edue;
    bit  pend = 1'b0;
    bit  exp_busy, exp_ov;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic real fabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    task automatic chk_r(input string nm, input real act, input real expv, input real tol);
        nchk++;
        if (!(fabs(act - expv) <= tol)) begin
            nerr++;
            $display("FAIL %s: got %g expected %g (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Textbook elimination on ga/gy; lat counts one clock per pivot and per row update.
    task automatic model(output int lat);
        real w [3][3];
        real v [3];
        real t, fac;
        int  p;
        w = ga; v = gy; es = 1'b0; lat = 0;
        for (int k = 0; k < 2; k++) begin
            lat++;
            p = k;
            for (int r = k + 1; r < 3; r++)
                if (fabs(w[r][k]) > fabs(w[p][k])) p = r;
            for (int c = 0; c < 3; c++) begin
                t = w[k][c]; w[k][c] = w[p][c]; w[p][c] = t;
            end
            t = v[k]; v[k] = v[p]; v[p] = t;
            if (fabs(w[k][k]) <= 0.0) begin
                es = 1'b1;
                continue;
            end
            for (int r = k + 1; r < 3; r++) begin
                lat++;
                fac = w[r][k] / w[k][k];
                for (int c = k + 1; c < 3; c++) w[r][c] = w[r][c] - fac * w[k][c];
                w[r][k] = 0.0;
                v[r] = v[r] - fac * v[k];
            end
        end
        if (fabs(w[2][2]) <= 0.0) es = 1'b1;
        eM = w; eb = v;
    endtask

    task automatic strobe3(input bit accept);
        int lat;
        io3.A = ga;
        io3.y = gy;
        io3.in_valid = 1'b1;
        @(posedge clk);
        #1;
        io3.in_valid = 1'b0;
        if (accept) begin
            model(lat);
            ecap = cyc;
            edue = cyc + lat;
            pend = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            exp_busy = pend && (cyc > ecap) && (cyc < edue);
            exp_ov   = pend && (cyc == edue);
            chk_b("busy", io3.busy, exp_busy);
            chk_b("out_valid", io3.out_valid, exp_ov);
            if (exp_ov) begin
                if (io3.out_valid) begin
                    for (int r = 0; r < 3; r++) begin
                        chk_r($sformatf("M[%0d] col0", r), io3.M[r][0], eM[r][0], 1e-12);
                        chk_r($sformatf("M[%0d] col1", r), io3.M[r][1], eM[r][1], 1e-12);
                        chk_r($sformatf("M[%0d] col2", r), io3.M[r][2], eM[r][2], 1e-12);
                        chk_r($sformatf("b[%0d]", r), io3.b[r], eb[r], 1e-12);
                    end
                    chk_b("singular", io3.singular, es);
                end
                pend = 1'b0;
            end
        end
    end

    initial begin
        io3.in_valid = 1'b0;
        io1.in_valid = 1'b0;
        io1.A[0][0] = 0.0;
        io1.y[0] = 0.0;
        for (int r = 0; r < 3; r++) begin
            gy[r] = 0.0;
            for (int c = 0; c < 3; c++) ga[r][c] = 0.0;
        end
        io3.A = ga;
        io3.y = gy;
        repeat (3) @(posedge clk);
        #1;
        chk_b("reset busy", io3.busy, 1'b0);
        chk_b("reset out_valid", io3.out_valid, 1'b0);
        chk_b("reset singular", io3.singular, 1'b0);
        chk_r("reset M[1][2]", io3.M[1][2], 0.0, 0.0);
        chk_r("reset b[2]", io3.b[2], 0.0, 0.0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Pivoting case with hand-computed literals.
        ga = '{'{2.0, 1.0, 1.0}, '{4.0, 3.0, 3.0}, '{8.0, 7.0, 9.0}};
        gy = '{4.0, 10.0, 24.0};
        strobe3(1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk_b("pivot out_valid at E0+5", io3.out_valid, 1'b1);
        chk_r("pivot M00", io3.M[0][0], 8.0, 1e-12);
        chk_r("pivot M02", io3.M[0][2], 9.0, 1e-12);
        chk_r("pivot M11", io3.M[1][1], -0.75, 1e-12);
        chk_r("pivot M12", io3.M[1][2], -1.25, 1e-12);
        chk_r("pivot M21", io3.M[2][1], 0.0, 0.0);
        chk_r("pivot M22", io3.M[2][2], -2.0 / 3.0, 1e-12);
        chk_r("pivot b0", io3.b[0], 24.0, 1e-12);
        chk_r("pivot b1", io3.b[1], -2.0, 1e-12);
        chk_r("pivot b2", io3.b[2], -2.0 / 3.0, 1e-12);
        chk_b("pivot singular", io3.singular, 1'b0);
        @(posedge clk); #1;
        chk_b("pulse one cycle", io3.out_valid, 1'b0);
        chk_r("hold M22", io3.M[2][2], -2.0 / 3.0, 1e-12);

        // Already triangular: bit-exact passthrough.
        ga = '{'{1.0, 2.0, 3.0}, '{0.0, 4.0, 5.0}, '{0.0, 0.0, 6.0}};
        gy = '{10.0, 20.0, 30.0};
        strobe3(1'b1);
        repeat (5) @(posedge clk);
        #1;
        for (int r = 0; r < 3; r++) begin
            chk_r($sformatf("tri b[%0d]", r), io3.b[r], gy[r], 0.0);
            for (int c = 0; c < 3; c++)
                chk_r($sformatf("tri M[%0d][%0d]", r, c), io3.M[r][c], ga[r][c], 0.0);
        end

        // Singular system.
        ga = '{'{1.0, 2.0, 3.0}, '{2.0, 4.0, 6.0}, '{1.0, 1.0, 1.0}};
        gy = '{1.0, 2.0, 3.0};
        strobe3(1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk_b("sing out_valid at E0+5", io3.out_valid, 1'b1);
        chk_b("sing flag", io3.singular, 1'b1);
        chk_r("sing M22", io3.M[2][2], 0.0, 0.0);
        @(posedge clk); #1;

        // Busy rejection, then back-to-back accept on the out_valid cycle.
        ga = '{'{2.0, 1.0, 1.0}, '{4.0, 3.0, 3.0}, '{8.0, 7.0, 9.0}};
        gy = '{4.0, 10.0, 24.0};
        strobe3(1'b1);
        @(posedge clk); #1;
        ga = '{'{1.0, 2.0, 3.0}, '{0.0, 4.0, 5.0}, '{0.0, 0.0, 6.0}};
        gy = '{10.0, 20.0, 30.0};
        strobe3(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_b("busy-reject out_valid", io3.out_valid, 1'b1);
        chk_r("busy-reject M00", io3.M[0][0], 8.0, 1e-12);
        chk_r("busy-reject b2", io3.b[2], -2.0 / 3.0, 1e-12);
        ga = '{'{1.0, 2.0, 3.0}, '{2.0, 4.0, 6.0}, '{1.0, 1.0, 1.0}};
        gy = '{1.0, 2.0, 3.0};
        strobe3(1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk_b("chained out_valid", io3.out_valid, 1'b1);
        chk_b("chained singular", io3.singular, 1'b1);
        @(posedge clk); #1;

        // Reset in the middle of an operation.
        ga = '{'{2.0, 1.0, 1.0}, '{4.0, 3.0, 3.0}, '{8.0, 7.0, 9.0}};
        gy = '{4.0, 10.0, 24.0};
        strobe3(1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        pend = 1'b0;
        reset = 1'b0;
        chk_b("abort busy", io3.busy, 1'b0);
        chk_b("abort out_valid", io3.out_valid, 1'b0);
        chk_r("abort M00", io3.M[0][0], 0.0, 0.0);
        chk_r("abort b0", io3.b[0], 0.0, 0.0);
        repeat (6) @(posedge clk);
        #1;
        ga = '{'{1.0, 2.0, 3.0}, '{0.0, 4.0, 5.0}, '{0.0, 0.0, 6.0}};
        gy = '{10.0, 20.0, 30.0};
        strobe3(1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk_b("post-reset out_valid", io3.out_valid, 1'b1);
        chk_r("post-reset M22", io3.M[2][2], 6.0, 0.0);
        @(posedge clk); #1;

        // N=1 instance.
        io1.A[0][0] = 4.0;
        io1.y[0] = 8.0;
        io1.in_valid = 1'b1;
        @(posedge clk); #1;
        io1.in_valid = 1'b0;
        chk_b("n1 out_valid at E0", io1.out_valid, 1'b0);
        @(posedge clk); #1;
        chk_b("n1 out_valid at E0+1", io1.out_valid, 1'b1);
        chk_b("n1 busy", io1.busy, 1'b0);
        chk_r("n1 M", io1.M[0][0], 4.0, 0.0);
        chk_r("n1 b", io1.b[0], 8.0, 0.0);
        chk_b("n1 singular", io1.singular, 1'b0);
        io1.A[0][0] = 0.0;
        io1.in_valid = 1'b1;
        @(posedge clk); #1;
        io1.in_valid = 1'b0;
        @(posedge clk); #1;
        chk_b("n1 zero out_valid", io1.out_valid, 1'b1);
        chk_b("n1 zero singular", io1.singular, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
